// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers of the execute stage.
// The multiply runs for MUL_LAT cycles. The divide is restoring radix-2 with a final sign-fix cycle.
module muldiv_hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand magnitudes at acceptance time; op[0]=1 selects the unsigned variants.
  logic             src_a_neg, src_b_neg;
  logic [WIDTH-1:0] src_a_mag, src_b_mag;

  // The product is built from operands held stable for MUL_LAT cycles (multicycle path).
  logic [2*WIDTH-1:0] mul_x, mul_y, mul_prod;

  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_sub;

  logic             q_neg, r_neg, div_zero;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  always_comb begin
    src_a_neg = ~op[0] & src_a[WIDTH-1];
    src_b_neg = ~op[0] & src_b[WIDTH-1];
    src_a_mag = src_a_neg ? -src_a : src_a;
    src_b_mag = src_b_neg ? -src_b : src_b;

    // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of a plain product correct for both modes.
    mul_x    = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    mul_y    = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    mul_prod = mul_x * mul_y;

    rem_sh  = {rem_q, quot_q[WIDTH-1]};
    div_ge  = rem_sh >= {1'b0, dvs_q};
    rem_sub = rem_sh[WIDTH-1:0] - dvs_q;

    q_neg    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg    = sgn_q & a_q[WIDTH-1];
    div_zero = (b_q == '0);
    fix_lo   = q_neg ? -quot_q : quot_q;
    fix_hi   = r_neg ? -rem_q : rem_q;
  end

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = ~op[0];
              cnt_d   = '0;
              state_d = S_MUL;
            end
            3'b010, 3'b011: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = ~op[0];
              quot_d  = src_a_mag;
              dvs_d   = src_b_mag;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            3'b100:  hi_d = src_a;
            3'b101:  lo_d = src_a;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (cnt_q == MUL_LAST) begin
          {hi_d, lo_d} = mul_prod;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DIV: begin
        // The dividend shifts out of the quotient register while quotient bits shift in.
        rem_d  = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], div_ge};
        if (cnt_q == DIV_LAST) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIX: begin
        if (div_zero) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = fix_lo;
          hi_d = fix_hi;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A flush wins over everything, including a same-cycle start or an HI/LO move.
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: table of arithmetic vectors plus hand-written
// sequences for back-to-back issue, HI/LO moves, flush and asynchronous reset.
module tb_muldiv_hilo_unit;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = WIDTH + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_hi, m_lo;

  typedef struct {
    string            name;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               lat;
    logic [WIDTH-1:0] exp_hi;
    logic [WIDTH-1:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  muldiv_hilo_unit #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst && busy && start) begin
      errors++;
      $display("FAIL start_while_busy: start=%0b busy=%0b required start=0 while busy", start, busy);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called in cycle 1 (just after the accepting edge); walks the busy cycles and the done cycle.
  task automatic expect_result(input string name, input int lat,
                               input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c <= lat) begin
        check({name, "_busy"}, {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});
      end else begin
        check({name, "_done"}, {62'd0, busy, done}, {62'd0, 1'b0, 1'b1});
        check({name, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check({name, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic count_done(input string name, input int cycles);
    int n;
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) n++;
    end
    check(name, 64'(n), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{"mult_m2x3",     OP_MULT,  32'hFFFFFFFE, 32'd3,        MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"mult_min_sq",   OP_MULT,  32'h80000000, 32'h80000000, MUL_LAT, 32'h40000000, 32'h00000000};
    vecs[3]  = '{"mult_m1xm1",    OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'h00000000, 32'h00000001};
    vecs[4]  = '{"multu_min_x2",  OP_MULTU, 32'h80000000, 32'd2,        MUL_LAT, 32'h00000001, 32'h00000000};
    vecs[5]  = '{"div_m7_2",      OP_DIV,   32'hFFFFFFF9, 32'd2,        DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6]  = '{"divu_7_2",      OP_DIVU,  32'd7,        32'd2,        DIV_LAT, 32'h00000001, 32'h00000003};
    vecs[7]  = '{"divu_by_zero",  OP_DIVU,  32'h00001234, 32'd0,        DIV_LAT, 32'h00001234, 32'hFFFFFFFF};
    vecs[8]  = '{"div_min_m1",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h00000000, 32'h80000000};
    vecs[9]  = '{"div_100_m7",    OP_DIV,   32'd100,      32'hFFFFFFF9, DIV_LAT, 32'h00000002, 32'hFFFFFFF2};
    vecs[10] = '{"div_m100_7",    OP_DIV,   32'hFFFFFF9C, 32'd7,        DIV_LAT, 32'hFFFFFFFE, 32'hFFFFFFF2};
    vecs[11] = '{"div_neg_by_0",  OP_DIV,   32'hFFFFFFF9, 32'd0,        DIV_LAT, 32'hFFFFFFF9, 32'hFFFFFFFF};

    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    src_a = '0;
    src_b = '0;
    #12;
    check("reset_state", {busy, done, hi, lo}, {1'b0, 1'b0, 64'd0});
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      expect_result(vecs[i].name, vecs[i].lat, vecs[i].exp_hi, vecs[i].exp_lo);
    end
    m_hi = 32'hFFFFFFF9;
    m_lo = 32'hFFFFFFFF;

    // Back-to-back: a divide presented in the multiply's done cycle.
    issue(OP_MULTU, 32'd3, 32'd5);
    for (int c = 1; c <= MUL_LAT; c++) begin
      @(negedge clk);
      check("b2b_mul_busy", {63'd0, busy}, 64'd1);
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    op    = OP_DIVU;
    src_a = 32'd7;
    src_b = 32'd2;
    @(negedge clk);
    check("b2b_mul_done", {busy, done, hi, lo}, {1'b0, 1'b1, 32'd0, 32'd15});
    @(posedge clk);
    #1;
    start = 1'b0;
    expect_result("b2b_div", DIV_LAT, 32'd1, 32'd3);
    m_hi = 32'd1;
    m_lo = 32'd3;

    // MTHI then MTLO on consecutive cycles.
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = OP_MTHI;
    src_a = 32'hAAAA5555;
    @(posedge clk);
    #1;
    op    = OP_MTLO;
    src_a = 32'h0F0F0F0F;
    @(negedge clk);
    check("mthi_cycle1", {busy, done, hi, lo}, {1'b0, 1'b0, 32'hAAAA5555, m_lo});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("mtlo_cycle2", {busy, done, hi, lo}, {1'b0, 1'b0, 32'hAAAA5555, 32'h0F0F0F0F});
    m_hi = 32'hAAAA5555;
    m_lo = 32'h0F0F0F0F;

    // Reserved opcode does nothing.
    issue(OP_NOP, 32'h12345678, 32'd9);
    @(negedge clk);
    check("nop_ignored", {busy, done, hi, lo}, {1'b0, 1'b0, m_hi, m_lo});

    // Flush a divide in cycle 10.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_c10", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_c11", {busy, done, hi, lo}, {1'b0, 1'b0, m_hi, m_lo});
    count_done("flush_no_done", 40);
    check("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});

    // Flush and start together: the start is dropped.
    @(posedge clk);
    #1;
    start = 1'b1;
    flush = 1'b1;
    op    = OP_DIV;
    src_a = 32'd9;
    src_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_start_div", {63'd0, busy}, 64'd0);
    count_done("flush_start_no_done", 40);

    @(posedge clk);
    #1;
    start = 1'b1;
    flush = 1'b1;
    op    = OP_MTHI;
    src_a = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_start_mthi", {busy, hi, lo}, {1'b0, m_hi, m_lo});

    // Asynchronous reset in cycle 5 of a divide.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset", {busy, done, hi, lo}, {1'b0, 1'b0, 64'd0});
    @(posedge clk);
    #1;
    rst = 1'b1;
    count_done("reset_no_done", 40);
    check("reset_hilo_held", {hi, lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
